// File: rtl/burst_line_cache_pkg.sv
// burst_line_cache_pkg
//   Shared definitions for the single-line burst cache and the burst RAM
//   controller: RAM command encodings, default line geometry, the cache FSM
//   state type and the 32-bit byte-merge helper used on write hits.
package burst_line_cache_pkg;

    // Default geometry shared with the RAM controller.
    localparam int unsigned BURST_COUNT_DEF   = 4;
    localparam int unsigned DATA_BITWIDTH_DEF = 64;

    // Burst RAM command encodings.
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WB_CMD,
        WB_DATA,
        FILL_CMD,
        FILL_DATA,
        DONE
    } state_e;

    // Replace the bytes of old_w selected by strb with the bytes of new_w.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int unsigned i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/burst_line_cache_if.sv
// burst_line_cache_if
//   Bundles the CPU word port and the burst RAM controller port of
//   burst_line_cache.
//   slave  : cache view (serves CPU requests, issues RAM bursts)
//   master : environment view (CPU issuing requests, RAM returning beats)
//   CPU side : cpu_en, cpu_addr, cpu_wstrb, cpu_wdata -> cache;
//              cpu_rdata, cpu_ready <- cache
//   RAM side : br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask <- cache;
//              br_rd_data, br_rd_data_valid, br_busy -> cache
interface burst_line_cache_if
    import burst_line_cache_pkg::*;
#(
    parameter int unsigned RAM_DEPTH_BITWIDTH = 4,
    parameter int unsigned DATA_BITWIDTH      = DATA_BITWIDTH_DEF
);
    logic                            cpu_en;
    logic [RAM_DEPTH_BITWIDTH+2:0]   cpu_addr;
    logic [3:0]                      cpu_wstrb;
    logic [31:0]                     cpu_wdata;
    logic [31:0]                     cpu_rdata;
    logic                            cpu_ready;

    logic                            br_cmd;
    logic                            br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]   br_addr;
    logic [DATA_BITWIDTH-1:0]        br_wr_data;
    logic [DATA_BITWIDTH/8-1:0]      br_data_mask;
    logic [DATA_BITWIDTH-1:0]        br_rd_data;
    logic                            br_rd_data_valid;
    logic                            br_busy;

    modport slave (
        input  cpu_en, cpu_addr, cpu_wstrb, cpu_wdata,
        input  br_rd_data, br_rd_data_valid, br_busy,
        output cpu_rdata, cpu_ready,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );

    modport master (
        output cpu_en, cpu_addr, cpu_wstrb, cpu_wdata,
        output br_rd_data, br_rd_data_valid, br_busy,
        input  cpu_rdata, cpu_ready,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );

endinterface

// File: rtl/burst_line_cache.sv
// burst_line_cache
//   Single-line, write-back, write-allocate cache between a 32-bit CPU word
//   port and a 64-bit burst RAM controller. Hits complete in one cycle;
//   misses write back a dirty line, then refill it with one read burst, after
//   which the still-held request is served as a hit.
//   clk, rst : clock and synchronous active-high reset (shared with RAM)
//   bus      : CPU request/response and burst RAM command/data signals
module burst_line_cache
    import burst_line_cache_pkg::*;
#(
    parameter int unsigned RAM_DEPTH_BITWIDTH = 4,
    parameter int unsigned BURST_COUNT        = BURST_COUNT_DEF,
    parameter int unsigned DATA_BITWIDTH      = DATA_BITWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    burst_line_cache_if.slave bus
);

    localparam int unsigned BEAT_BITS = $clog2(BURST_COUNT);
    localparam int unsigned OFF       = BEAT_BITS + 3;
    localparam int unsigned ADDR_BITS = RAM_DEPTH_BITWIDTH + 3;
    localparam int unsigned TAG_BITS  = ADDR_BITS - OFF;

    typedef logic [DATA_BITWIDTH-1:0] beat_t;

    // Request address fields.
    logic [TAG_BITS-1:0]  req_tag;
    logic [BEAT_BITS-1:0] req_beat;
    logic                 req_half;
    logic                 hit;
    logic                 unused_addr_bits;

    assign req_tag          = bus.cpu_addr[ADDR_BITS-1:OFF];
    assign req_beat         = bus.cpu_addr[OFF-1:3];
    assign req_half         = bus.cpu_addr[2];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    state_e               state_q, state_d;
    beat_t                line_q [BURST_COUNT];
    beat_t                line_d [BURST_COUNT];
    logic [TAG_BITS-1:0]  line_tag_q, line_tag_d;
    logic                 valid_q, valid_d;
    logic                 dirty_q, dirty_d;
    logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;

    logic                          cpu_ready_q, cpu_ready_d;
    logic [31:0]                   cpu_rdata_q, cpu_rdata_d;
    logic                          br_cmd_en_q, br_cmd_en_d;
    logic                          br_cmd_q, br_cmd_d;
    logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q, br_addr_d;
    beat_t                         br_wr_data_q, br_wr_data_d;

    logic issue_wb;
    logic issue_fill;

    assign hit = valid_q && (req_tag == line_tag_q);

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        line_tag_d   = line_tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        beat_cnt_d   = beat_cnt_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        br_cmd_en_d  = 1'b0;
        br_cmd_d     = br_cmd_q;
        br_addr_d    = br_addr_q;
        br_wr_data_d = br_wr_data_q;
        issue_wb     = 1'b0;
        issue_fill   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_en) begin
                    if (hit) begin
                        if (bus.cpu_wstrb == '0) begin
                            cpu_rdata_d = req_half ? line_q[req_beat][63:32]
                                                   : line_q[req_beat][31:0];
                        end else begin
                            if (req_half) begin
                                line_d[req_beat][63:32] = merge_word(
                                    line_q[req_beat][63:32], bus.cpu_wdata, bus.cpu_wstrb);
                            end else begin
                                line_d[req_beat][31:0] = merge_word(
                                    line_q[req_beat][31:0], bus.cpu_wdata, bus.cpu_wstrb);
                            end
                            dirty_d = 1'b1;
                        end
                        cpu_ready_d = 1'b1;
                        state_d     = DONE;
                    end else if (valid_q && dirty_q) begin
                        // The command strobe is registered, so a miss seen
                        // with the RAM idle issues straight from IDLE to hit
                        // cycle 1; the *_CMD states only absorb busy stalls.
                        if (!bus.br_busy) issue_wb = 1'b1;
                        else              state_d  = WB_CMD;
                    end else begin
                        if (!bus.br_busy) issue_fill = 1'b1;
                        else              state_d    = FILL_CMD;
                    end
                end
            end
            WB_CMD: begin
                if (!bus.br_busy) issue_wb = 1'b1;
            end
            WB_DATA: begin
                br_wr_data_d = line_q[beat_cnt_q];
                beat_cnt_d   = beat_cnt_q + 1'b1;
                if (beat_cnt_q == BEAT_BITS'(BURST_COUNT - 1)) begin
                    dirty_d = 1'b0;
                    state_d = FILL_CMD;
                end
            end
            FILL_CMD: begin
                if (!bus.br_busy) issue_fill = 1'b1;
            end
            FILL_DATA: begin
                if (bus.br_rd_data_valid) begin
                    line_d[beat_cnt_q] = bus.br_rd_data;
                    beat_cnt_d         = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_BITS'(BURST_COUNT - 1)) begin
                        line_tag_d = req_tag;
                        valid_d    = 1'b1;
                        dirty_d    = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write-back burst: beat 0 goes out with the command strobe.
        if (issue_wb) begin
            br_cmd_en_d  = 1'b1;
            br_cmd_d     = CMD_WRITE;
            br_addr_d    = {line_tag_q, {BEAT_BITS{1'b0}}};
            br_wr_data_d = line_q[0];
            beat_cnt_d   = BEAT_BITS'(1);
            state_d      = WB_DATA;
        end

        // Fill burst: the line is invalid until the last beat lands.
        if (issue_fill) begin
            br_cmd_en_d = 1'b1;
            br_cmd_d    = CMD_READ;
            br_addr_d   = {req_tag, {BEAT_BITS{1'b0}}};
            beat_cnt_d  = '0;
            valid_d     = 1'b0;
            state_d     = FILL_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_tag_q   <= '0;
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            beat_cnt_q   <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            br_cmd_en_q  <= 1'b0;
            br_cmd_q     <= 1'b0;
            br_addr_q    <= '0;
            br_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            line_tag_q   <= line_tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            beat_cnt_q   <= beat_cnt_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            br_cmd_en_q  <= br_cmd_en_d;
            br_cmd_q     <= br_cmd_d;
            br_addr_q    <= br_addr_d;
            br_wr_data_q <= br_wr_data_d;
        end
    end

    // Line storage carries no reset; valid_q gates every use of it.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.br_cmd_en    = br_cmd_en_q;
    assign bus.br_cmd       = br_cmd_q;
    assign bus.br_addr      = br_addr_q;
    assign bus.br_wr_data   = br_wr_data_q;
    assign bus.br_data_mask = '0;

endmodule

// File: doc/burst_line_cache.md
# burst_line_cache

Single-line, write-back, write-allocate cache between the CPU's 32-bit word port and the 64-bit burst RAM controller. Holds exactly one RAM line (BURST_COUNT beats of DATA_BITWIDTH). Hits are served in one cycle. Misses write back the line if it is dirty, then fill it with one read burst. This block is the sole issuer of burst commands to the RAM.

## Interface
- RAM_DEPTH_BITWIDTH, 4, RAM address width in 8-byte beats.
- BURST_COUNT, 4, beats per line; power of two.
- DATA_BITWIDTH, 64, RAM beat width; fixed at 64.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. Shared with the RAM controller.
- cpu_en  in  1  request valid; held with addr/wstrb/wdata stable until cpu_ready.
- cpu_addr  in  RAM_DEPTH_BITWIDTH+3  byte address; bits [1:0] ignored.
- cpu_wstrb  in  4  byte write enables; 0 = read.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- br_cmd  out  1  0 read, 1 write.
- br_cmd_en  out  1  command strobe, one cycle.
- br_addr  out  RAM_DEPTH_BITWIDTH  line base beat address; low log2(BURST_COUNT) bits are 0.
- br_wr_data  out  64  write beat.
- br_data_mask  out  8  tied 0.
- br_rd_data  in  64  read beat.
- br_rd_data_valid  in  1  read beat valid.
- br_busy  in  1  RAM controller busy.

## Operation
- Address split: OFF = log2(BURST_COUNT)+3.
  - tag = cpu_addr[MSB:OFF].
  - beat = cpu_addr[OFF-1:3].
  - half = cpu_addr[2]; 1 selects bits [63:32].
- State: line[BURST_COUNT], line_tag, valid, dirty.
- FSM states: IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, DONE.
- IDLE:
  - If cpu_en is high and (valid && tag==line_tag): hit.
    - Read: cpu_rdata <= selected word.
    - Write: merge the wstrb bytes into the line; dirty <= 1.
    - Then cpu_ready <= 1 and go to DONE.
  - Miss with valid&&dirty: go to WB_CMD.
  - Other miss: go to FILL_CMD.
- WB_CMD:
  - Waits for br_busy==0.
  - Then drives, for one cycle: br_cmd_en=1, br_cmd=1, br_addr={line_tag,0}, br_wr_data=line[0]. Goes to WB_DATA.
- WB_DATA:
  - Drives line[1..BURST_COUNT-1] on consecutive cycles.
  - br_cmd_en=0 throughout.
  - Then dirty <= 0 and go to FILL_CMD.
- FILL_CMD:
  - Waits for br_busy==0.
  - Then drives, for one cycle: br_cmd_en=1, br_cmd=0, br_addr={tag,0}. Goes to FILL_DATA.
- FILL_DATA:
  - Each cycle with br_rd_data_valid=1, stores br_rd_data into line[k]; k counts 0..BURST_COUNT-1.
  - After beat BURST_COUNT-1: line_tag <= tag, valid <= 1, dirty <= 0, go to IDLE.
  - The still-held request then hits.
- DONE: cpu_ready <= 0; cpu_en is not sampled in this state; go to IDLE.
- br_rd_data_valid outside FILL_DATA is ignored.
- Write miss is write-allocate: fill first, then merge in IDLE.
- Wait states have no timeout; the read delay is arbitrary, and only beats are counted.

## Timing
- All outputs are registered.
- Reset values: cpu_ready=0, cpu_rdata=0, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0. Also valid=0, dirty=0, state IDLE.
- Convention: cpu_en is first high in cycle 0.
- Hit: cpu_ready in cycle 1. Next request is sampled no earlier than cycle 2.
- Clean miss: br_cmd_en in cycle 1.
  - With RAM read delay 8, beats arrive in cycles 11–14 and cpu_ready rises in cycle 16.
- Dirty miss:
  - Write beats on br_wr_data in cycles 1–4; br_cmd_en only in cycle 1.
  - RAM br_busy is high in cycles 2–5.
  - Fill br_cmd_en in cycle 7; cpu_ready in cycle 22.
- br_busy high when entering WB_CMD/FILL_CMD: stall until low; at most one command strobe per busy-low cycle.
- Reset mid-operation: the FSM returns to IDLE and the line is invalidated. Dirty data is discarded. The RAM is reset in the same cycle.

## Structure
- Shared package/header holds:
  - RAM command encodings CMD_READ=0 and CMD_WRITE=1.
  - Default geometry constants BURST_COUNT=4 and DATA_BITWIDTH=64, shared with the RAM controller.
  - This block's FSM state encodings.
- No sub-module. The line is a register array with a 32-bit byte-merge function.

## Test plan
- Reset → all outputs 0. A read of 0x00 after reset is a miss: br_cmd_en=1 in cycle 1 with br_cmd=0, br_addr=0.
- RAM data[0]=64'h11111111_22222222. Read 0x04 (clean miss, delay 8) → cpu_ready in cycle 16, cpu_rdata=32'h11111111. Then read 0x08 → hit, ready 1 cycle later, rdata = low word of data[1].
- Write hit 0x00 with wdata=32'hAABBCCDD, wstrb=4'b0011 → ready next cycle, no br_cmd_en. Then read 0x00 → 32'h2222CCDD.
- With the dirty line 0 cached, read 0x20 → write burst of line 0 in cycles 1–4, fill cmd_en in cycle 7, ready in cycle 22. RAM data[0] = 64'h11111111_2222CCDD.
- Assert rst in cycle 12 of a fill → br_cmd_en=0, cpu_ready=0. The same read re-issued afterwards misses again and issues a new fill.
- Stray br_rd_data_valid pulses in IDLE → line contents unchanged; a subsequent hit returns the original data.
